riscv_lsu: RTL and testbench

- Load/store unit directly downstream of the ALU in the RISC-V datapath.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs a req/ack transaction with the data memory and stalls the core until the access completes.
- Returns sign- or zero-extended load data for register writeback.

---
 rtl/riscv_lsu.sv | 168 ++++++++++++++++
 tb/tb_riscv_lsu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: one req/ack memory access per load/store, core stalled until DONE (min 3 cycles, 2 stalled).
// Waits on dmem_ack up to TIMEOUT cycles; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,output logic             misaligned
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cap_lo;
  logic [2:0]       cap_f3;

  logic             access;
  logic [3:0]       be_nxt;
  logic [31:0]      wd_nxt;
  logic             trap;
  logic             timeout_hit;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      ld_ext;

  assign access      = mem_read | mem_write;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // funct3[1:0]: 00 byte, 01 half, anything else is a word access
  always_comb begin
    be_nxt = 4'b1111;
    wd_nxt = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_nxt = 4'b0001 << addr[1:0];
        wd_nxt = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_nxt = addr[1] ? 4'b1100 : 4'b0011;
        wd_nxt = {2{wdata[15:0]}};
      end
      default: begin
        be_nxt = 4'b1111;
        wd_nxt = wdata;
      end
    endcase
    if (!mem_write) wd_nxt = '0;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((funct3[1:0] == 2'b01) && addr[0]) ||
                (funct3[1] && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    case (cap_lo)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = cap_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_f3[1:0])
      2'b00:   ld_ext = {{24{~cap_f3[2] & byte_sel[7]}}, byte_sel};
      2'b01:   ld_ext = {{16{~cap_f3[2] & half_sel[15]}}, half_sel};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = access & ~reset;
      REQ:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_lo     <= '0;
      cap_f3     <= '0;
      rdata      <= '0;
      bus_err    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && trap) begin
            state <= DONE;
          end else if (access) begin
            state      <= REQ;
            cnt        <= '0;
            cap_lo     <= addr[1:0];
            cap_f3     <= funct3;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            dmem_be    <= be_nxt;
            dmem_wdata <= wd_nxt;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) rdata <= ld_ext;
            state <= DONE;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned <= 1'b0;
    end else if (state == IDLE && access && trap) begin
      misaligned <= 1'b1;
    end else if (state == DONE) begin
      misaligned <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with TIMEOUT=4.
module tb_riscv_lsu;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks;
  int failures;

  riscv_lsu #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .bus_err    (bus_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,.misaligned(misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    checks++;
    if (dmem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", dmem_we); end
    checks++;
    if (dmem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", dmem_addr); end
    checks++;
    if (dmem_be !== 4'h0) begin failures++; $display("FAIL reset_be got=%b exp=0000", dmem_be); end
    checks++;
    if (dmem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", dmem_wdata); end
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store_word();
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h0000_1006; wdata = 32'hDEAD_BEEF;
    #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL sw_stall_idle got=%b exp=1", stall); end
    checks++;
    tick();
    if (dmem_req !== 1'b1) begin failures++; $display("FAIL sw_req got=%b exp=1", dmem_req); end
    checks++;
    if (dmem_addr !== 32'h0000_1004) begin failures++; $display("FAIL sw_addr got=%h exp=00001004", dmem_addr); end
    checks++;
    if (dmem_be !== 4'b1111) begin failures++; $display("FAIL sw_be got=%b exp=1111", dmem_be); end
    checks++;
    if (dmem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", dmem_wdata); end
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL sw_stall_req got=%b exp=1", stall); end
    checks++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    if (stall !== 1'b0) begin failures++; $display("FAIL sw_stall_done got=%b exp=0", stall); end
    checks++;
    if (dmem_req !== 1'b0) begin failures++; $display("FAIL sw_req_done got=%b exp=0", dmem_req); end
    checks++;
    mem_write = 1'b0;
    tick();
  endtask

  task automatic test_store_byte();
    mem_write = 1'b1; funct3 = 3'b000; addr = 32'h0000_2003; wdata = 32'h0000_00A5;
    tick();
    if (dmem_be !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", dmem_be); end
    checks++;
    if (dmem_wdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", dmem_wdata); end
    checks++;
    if (dmem_we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", dmem_we); end
    checks++;
    if (dmem_addr !== 32'h0000_2000) begin failures++; $display("FAIL sb_addr got=%h exp=00002000", dmem_addr); end
    checks++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    mem_write = 1'b0;
    tick();
  endtask

`ifndef LSU_MISALIGN_TRAP_EN
  task automatic test_store_half_unaligned();
    mem_write = 1'b1; funct3 = 3'b001; addr = 32'h0000_2007; wdata = 32'h1111_BEEF;
    tick();
    if (dmem_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", dmem_be); end
    checks++;
    if (dmem_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", dmem_wdata); end
    checks++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    mem_write = 1'b0;
    tick();
  endtask
`endif

  task automatic test_loads();
    // LB at byte 1 of 0x123480FF -> 0x80 sign-extended
    mem_read = 1'b1; funct3 = 3'b000; addr = 32'h0000_3001;
    tick();
    if (dmem_be !== 4'b0010) begin failures++; $display("FAIL lb_be got=%b exp=0010", dmem_be); end
    checks++;
    if (dmem_we !== 1'b0) begin failures++; $display("FAIL lb_we got=%b exp=0", dmem_we); end
    checks++;
    if (dmem_wdata !== 32'h0) begin failures++; $display("FAIL lb_wdata got=%h exp=0", dmem_wdata); end
    checks++;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_80FF;
    tick();
    dmem_ack = 1'b0; mem_read = 1'b0;
    if (rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
    checks++;
    tick();

    mem_read = 1'b1; funct3 = 3'b100; addr = 32'h0000_3001;
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0; mem_read = 1'b0;
    if (rdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", rdata); end
    checks++;
    tick();

    mem_read = 1'b1; funct3 = 3'b001; addr = 32'h0000_3000;
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0; mem_read = 1'b0;
    if (rdata !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff80ff", rdata); end
    checks++;
    tick();

    mem_read = 1'b1; funct3 = 3'b101; addr = 32'h0000_3002;
    tick();
    if (dmem_be !== 4'b1100) begin failures++; $display("FAIL lhu_be got=%b exp=1100", dmem_be); end
    checks++;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0; mem_read = 1'b0;
    if (rdata !== 32'h0000_1234) begin failures++; $display("FAIL lhu_rdata got=%h exp=00001234", rdata); end
    checks++;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000; dmem_rdata = 32'h5555_AAAA;
    tick();
    n = 0;
    while (dmem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    mem_read = 1'b0;
    if (n !== 4) begin failures++; $display("FAIL to_req_cycles got=%0d exp=4", n); end
    checks++;
    if (bus_err !== 1'b1) begin failures++; $display("FAIL to_bus_err got=%b exp=1", bus_err); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL to_stall got=%b exp=0", stall); end
    checks++;
    if (rdata !== 32'h0000_1234) begin failures++; $display("FAIL to_rdata got=%h exp=00001234", rdata); end
    checks++;
    tick();
    if (bus_err !== 1'b0) begin failures++; $display("FAIL to_bus_err_clr got=%b exp=0", bus_err); end
    checks++;
  endtask

  task automatic test_reset_mid();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6008;
    tick();
    if (dmem_req !== 1'b1) begin failures++; $display("FAIL rm_req_before got=%b exp=1", dmem_req); end
    checks++;
    #2;
    reset = 1'b1;
    #1;
    if (dmem_req !== 1'b0) begin failures++; $display("FAIL rm_req got=%b exp=0", dmem_req); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL rm_stall got=%b exp=0", stall); end
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL rm_bus_err got=%b exp=0", bus_err); end
    checks++;
    mem_read = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    if (rdata !== 32'h0) begin failures++; $display("FAIL rm_rdata_clr got=%h exp=0", rdata); end
    checks++;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6008;
    tick();
    if (dmem_addr !== 32'h0000_6008) begin failures++; $display("FAIL rm_addr got=%h exp=00006008", dmem_addr); end
    checks++;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0; mem_read = 1'b0;
    if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL rm_rdata got=%h exp=cafef00d", rdata); end
    checks++;
    tick();
  endtask

  task automatic test_ack_in_idle();
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_ack = 1'b0;
    if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL idle_ack_rdata got=%h exp=cafef00d", rdata); end
    checks++;
    if (dmem_req !== 1'b0) begin failures++; $display("FAIL idle_ack_req got=%b exp=0", dmem_req); end
    checks++;
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic test_misalign_trap();
    mem_read = 1'b1; funct3 = 3'b001; addr = 32'h0000_4001;
    #1;
    if (stall !== 1'b1) begin failures++; $display("FAIL ma_stall_idle got=%b exp=1", stall); end
    checks++;
    tick();
    mem_read = 1'b0;
    if (misaligned !== 1'b1) begin failures++; $display("FAIL ma_flag got=%b exp=1", misaligned); end
    checks++;
    if (dmem_req !== 1'b0) begin failures++; $display("FAIL ma_req got=%b exp=0", dmem_req); end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL ma_stall_done got=%b exp=0", stall); end
    checks++;
    tick();
    if (misaligned !== 1'b0) begin failures++; $display("FAIL ma_flag_clr got=%b exp=0", misaligned); end
    checks++;
    if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL ma_rdata got=%h exp=cafef00d", rdata); end
    checks++;
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    test_reset();
    test_store_word();
    test_store_byte();
`ifndef LSU_MISALIGN_TRAP_EN
    test_store_half_unaligned();
`endif
    test_loads();
    test_timeout();
    test_reset_mid();
    test_ack_in_idle();
`ifdef LSU_MISALIGN_TRAP_EN
    test_misalign_trap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
